move_ctrl: RTL and testbench
============================

# move_ctrl

Player-input side of the tic-tac-toe board store: turns debounced button pulses into cursor moves and single-cycle cell writes on the board's write port (`waddr`/`wen`/`I`), reading back the addressed cell on `wY` to reject moves onto occupied cells. It alternates players and tracks the move count. Once the board's `gameover` vector is non-zero, the next select press clears the board and restarts play. It sits between the button debouncers and the board register array.

## Interface
Parameters:
- `START_PLAYER`, default 2'b01: mark written on the first move after reset or clear; 2'b01 = X, 2'b10 = O.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  debounced single-cycle press pulses.
- `btn_sel`  in  1  debounced single-cycle select pulse.
- `wY`  in  2  contents of cell `waddr`, combinational from the board store. 00 = empty, 01 = X, 10 = O, 11 = reserved (treated as occupied).
- `gameover`  in  10  board result vector; any bit set means the game has ended.
- `waddr`  out  4  cursor cell address, row-major: addr = row*4 + col.
- `wen`  out  1  write strobe to the board store.
- `I`  out  2  data written when `wen` is high.
- `turn`  out  2  player to move: 01 or 10.
- `move_cnt`  out  5  accepted moves since reset or clear, 0..16.
- `err`  out  1  one-cycle pulse when select targets an occupied cell.

## Operation
- States:
  - IDLE: accepts button input.
  - WRITE: `wen`=1, `I`=`turn`, exactly 1 cycle.
  - SETTLE: 1 cycle, lets `gameover` reflect the new board.
  - CLEAR: `wen`=1, `I`=00, exactly 1 cycle.
- IDLE, `btn_sel`=1:
  - `gameover`≠0 → CLEAR (the board store zeroes the whole board on any `wen` while game is over).
  - else `wY`==00 → WRITE.
  - else (`wY`=01/10/11) → `err`=1 for the next cycle; stay in IDLE; no write.
- WRITE → SETTLE. On leaving WRITE: `turn` toggles 01↔10; `move_cnt` += 1, saturating at 16.
- SETTLE → IDLE unconditionally.
- CLEAR → IDLE. On leaving CLEAR: cursor = 0, `turn` = START_PLAYER, `move_cnt` = 0.
- Cursor moves, IDLE only, one step per pulse, wrapping within the row or column:
  - up: row−1, row 0 → 3.
  - down: row+1, row 3 → 0.
  - left: col−1, col 0 → 3.
  - right: col+1, col 3 → 0.
- Simultaneous pulses:
  - `btn_sel` wins over direction buttons; directions are ignored that cycle.
  - Among directions: up > down > left > right; only one applies.
- Buttons pressed in WRITE, SETTLE or CLEAR are dropped, not queued.
- Cursor, and therefore `waddr`, is frozen outside IDLE, so `wY`/`waddr` are stable through the write.
- Cursor moves are allowed while the game is over; only select triggers the clear.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, `waddr`=0, `wen`=0, `I`=00, `turn`=START_PLAYER, `move_cnt`=0, `err`=0.
- Reset asserted mid-WRITE or mid-CLEAR drops `wen` immediately (asynchronously); no partial update beyond what the store itself latches.
- All outputs are registered; none is combinational from inputs.
- Select at edge N (IDLE, empty cell): `wen`=1 during cycle N+1; the board updates at edge N+2; `turn`/`move_cnt` update at edge N+2; back in IDLE from edge N+3. Next select is accepted at edge N+3.
- Occupied select at edge N: `err`=1 during cycle N+1 only; `wen` stays 0.
- Clear select at edge N: `wen`=1, `I`=00 during cycle N+1; cursor/turn/count reset at edge N+2; IDLE from edge N+2.
- Direction pulse at edge N: `waddr` updates at edge N+1.

## Test plan
- Reset, no input → `waddr`=0, `wen`=0, `turn`=01, `move_cnt`=0, `err`=0; with `rst_n` low mid-WRITE, `wen` drops without waiting for a clock.
- From cell 0: left → `waddr`=3; up → 15; right → 12; down → 0; up+left same cycle → `waddr`=12 (up only).
- Empty cell 5, select → `wen` high exactly 1 cycle with `waddr`=5, `I`=01; then `turn`=10, `move_cnt`=1; select pressed during SETTLE is dropped.
- `wY`=01 at cursor, select → `err` high 1 cycle, `wen` never high, `turn` and `move_cnt` unchanged.
- `gameover`=10'h001, cursor 9, select → `wen`=1, `I`=00 for 1 cycle; then `waddr`=0, `turn`=01, `move_cnt`=0.
- 16 accepted moves alternating 01/10 → `move_cnt`=16; a further WRITE keeps `move_cnt` at 16.

Source files
------------

// File: rtl/move_ctrl.sv
// Tic-tac-toe player-input controller: converts debounced button pulses into
// cursor moves and single-cycle writes/clears on the board store's write port.
module move_ctrl #(
  parameter logic [1:0] START_PLAYER = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic [1:0] wY,
  input  logic [9:0] gameover,
  output logic [3:0] waddr,
  output logic       wen,
  output logic [1:0] I,
  output logic [1:0] turn,
  output logic [4:0] move_cnt,
  output logic       err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WRITE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] CLEAR  = 2'd3;

  localparam logic [4:0] MAX_MOVES = 5'd16;

  logic [1:0] state;
  logic [1:0] row;
  logic [1:0] col;

  // Cursor is stored as row/col so wrapping falls out of 2-bit arithmetic.
  assign waddr = {row, col};

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see half-updated values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= 2'd0;
      col      <= 2'd0;
      wen      <= 1'b0;
      I        <= 2'b00;
      turn     <= START_PLAYER;
      move_cnt <= 5'd0;
      err      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      wen <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sel) begin
            if (gameover != 10'd0) begin
              state <= CLEAR;
              wen   <= 1'b1;
              I     <= 2'b00;
            end else if (wY == 2'b00) begin
              state <= WRITE;
              wen   <= 1'b1;
              I     <= turn;
            end else begin
              err <= 1'b1;
            end
          end else if (btn_up) begin
            row <= row - 2'd1;
          end else if (btn_down) begin
            row <= row + 2'd1;
          end else if (btn_left) begin
            col <= col - 2'd1;
          end else if (btn_right) begin
            col <= col + 2'd1;
          end
        end
        WRITE: begin
          state <= SETTLE;
          turn  <= (turn == 2'b01) ? 2'b10 : 2'b01;
          if (move_cnt < MAX_MOVES) begin
            move_cnt <= move_cnt + 5'd1;
          end
        end
        SETTLE: begin
          // Gives the board store a cycle to update gameover before new input.
          state <= IDLE;
        end
        CLEAR: begin
          state    <= IDLE;
          row      <= 2'd0;
          col      <= 2'd0;
          turn     <= START_PLAYER;
          move_cnt <= 5'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_ctrl.sv
// Directed testbench for move_ctrl with a small board-store model driving wY.
module tb_move_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [1:0] wY;
  logic [9:0] gameover;
  logic [3:0] waddr;
  logic       wen;
  logic [1:0] I;
  logic [1:0] turn;
  logic [4:0] move_cnt;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  // Board store model; poke lets the bench free a cell without a DUT write.
  logic [1:0] board [16];
  logic       poke;
  logic [3:0] poke_addr;

  always #5 clk = ~clk;

  move_ctrl #(.START_PLAYER(2'b01)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_sel  (btn_sel),
    .wY       (wY),
    .gameover (gameover),
    .waddr    (waddr),
    .wen      (wen),
    .I        (I),
    .turn     (turn),
    .move_cnt (move_cnt),
    .err      (err)
  );

  assign wY = board[waddr];

  always @(posedge clk) begin
    if (poke) begin
      board[poke_addr] <= 2'b00;
    end else if (wen) begin
      if (gameover != 10'd0) begin
        for (int k = 0; k < 16; k++) board[k] <= 2'b00;
      end else begin
        board[waddr] <= I;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_up    = 1'b1;
      1: btn_down  = 1'b1;
      2: btn_left  = 1'b1;
      3: btn_right = 1'b1;
      default: btn_sel = 1'b1;
    endcase
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
  endtask

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, SEL = 4;

  initial begin
    rst_n = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
    gameover = 10'd0;
    poke = 1'b0;
    poke_addr = 4'd0;
    for (int k = 0; k < 16; k++) board[k] = 2'b00;

    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wen",   32'(wen),   32'd0);
    check("rst_I",     32'(I),     32'd0);
    check("rst_turn",  32'(turn),  32'd1);
    check("rst_cnt",   32'(move_cnt), 32'd0);
    check("rst_err",   32'(err),   32'd0);

    // Cursor wrapping
    press(LEFT);  check("left_wrap",  32'(waddr), 32'd3);
    press(UP);    check("up_wrap",    32'(waddr), 32'd15);
    press(RIGHT); check("right_wrap", 32'(waddr), 32'd12);
    press(DOWN);  check("down_wrap",  32'(waddr), 32'd0);
    btn_left = 1'b1;
    press(UP);    check("up_over_left", 32'(waddr), 32'd12);

    // Move to cell 5 and write
    press(DOWN); press(DOWN); press(RIGHT);
    check("at_cell5", 32'(waddr), 32'd5);
    press(SEL);
    check("wr_wen",   32'(wen),   32'd1);
    check("wr_addr",  32'(waddr), 32'd5);
    check("wr_I",     32'(I),     32'd1);
    tick();
    check("wr_wen_1cyc", 32'(wen), 32'd0);
    check("wr_turn",  32'(turn),  32'd2);
    check("wr_cnt",   32'(move_cnt), 32'd1);
    check("wr_board", 32'(board[5]), 32'd1);
    // Select and right during SETTLE are dropped
    btn_right = 1'b1;
    press(SEL);
    check("settle_wen",   32'(wen),   32'd0);
    check("settle_err",   32'(err),   32'd0);
    check("settle_waddr", 32'(waddr), 32'd5);
    tick();
    check("settle_noqueue_wen", 32'(wen), 32'd0);
    check("settle_noqueue_cnt", 32'(move_cnt), 32'd1);

    // Occupied cell
    press(SEL);
    check("occ_err", 32'(err), 32'd1);
    check("occ_wen", 32'(wen), 32'd0);
    tick();
    check("occ_err_1cyc", 32'(err), 32'd0);
    check("occ_wen2",  32'(wen),  32'd0);
    check("occ_turn",  32'(turn), 32'd2);
    check("occ_cnt",   32'(move_cnt), 32'd1);

    // Clear on game over; cursor still moves while game is over
    gameover = 10'h001;
    press(DOWN);
    check("go_move", 32'(waddr), 32'd9);
    press(SEL);
    check("clr_wen", 32'(wen), 32'd1);
    check("clr_I",   32'(I),   32'd0);
    check("clr_err", 32'(err), 32'd0);
    tick();
    gameover = 10'd0;
    check("clr_wen_1cyc", 32'(wen), 32'd0);
    check("clr_waddr", 32'(waddr), 32'd0);
    check("clr_turn",  32'(turn),  32'd1);
    check("clr_cnt",   32'(move_cnt), 32'd0);
    check("clr_board", 32'(board[5]), 32'd0);

    // Fill all 16 cells, alternating marks
    for (int i = 0; i < 16; i++) begin
      press(SEL);
      check($sformatf("fill_wen_%0d", i), 32'(wen), 32'd1);
      check($sformatf("fill_I_%0d", i), 32'(I), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick(); tick();
      press(RIGHT);
      if (i % 4 == 3) press(DOWN);
    end
    check("fill_cnt",   32'(move_cnt), 32'd16);
    check("fill_turn",  32'(turn),     32'd1);
    check("fill_waddr", 32'(waddr),    32'd0);
    check("fill_b15",   32'(board[15]), 32'd2);

    // One more write saturates the count
    poke = 1'b1; poke_addr = 4'd0;
    tick();
    poke = 1'b0;
    press(SEL);
    check("sat_wen", 32'(wen), 32'd1);
    tick(); tick();
    check("sat_cnt",  32'(move_cnt), 32'd16);
    check("sat_turn", 32'(turn),     32'd2);

    // Asynchronous reset in the middle of WRITE
    poke = 1'b1; poke_addr = 4'd0;
    tick();
    poke = 1'b0;
    press(SEL);
    check("arst_pre_wen", 32'(wen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wen",  32'(wen),      32'd0);
    check("arst_turn", 32'(turn),     32'd1);
    check("arst_cnt",  32'(move_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_after_wen", 32'(wen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
